// File: rtl/tone_pkg.sv
// Shared definitions for the tone source arbiter: note codes, octave clamp,
// octave-0 half-period table at 100 MHz, and the arbiter state encoding.
package tone_pkg;

    localparam logic [2:0] NOTE_REST = 3'd0;
    localparam logic [2:0] NOTE_C    = 3'd1;
    localparam logic [2:0] NOTE_D    = 3'd2;
    localparam logic [2:0] NOTE_E    = 3'd3;
    localparam logic [2:0] NOTE_F    = 3'd4;
    localparam logic [2:0] NOTE_G    = 3'd5;
    localparam logic [2:0] NOTE_A    = 3'd6;
    localparam logic [2:0] NOTE_B    = 3'd7;

    // Highest octave the tone path supports; requests above it are clamped.
    localparam logic [2:0] OCT_MAX   = 3'd6;

    // Width of a half-period count (largest entry 764455 < 2**20).
    localparam int HALF_W = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Octave-0 half period in clock cycles (C2..B2); rest maps to 0.
    function automatic logic [HALF_W-1:0] base_half(input logic [2:0] note);
        logic [HALF_W-1:0] h;
        case (note)
            NOTE_C:  h = 20'd764455;
            NOTE_D:  h = 20'd681050;
            NOTE_E:  h = 20'd606745;
            NOTE_F:  h = 20'd572692;
            NOTE_G:  h = 20'd510209;
            NOTE_A:  h = 20'd454545;
            NOTE_B:  h = 20'd404956;
            default: h = 20'd0;
        endcase
        return h;
    endfunction

    // Limit an octave request to the supported range.
    function automatic logic [2:0] clamp_octave(input logic [2:0] oct);
        logic [2:0] c;
        if (oct > OCT_MAX) begin
            c = OCT_MAX;
        end else begin
            c = oct;
        end
        return c;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: half-period counter plus toggle flop.
// load starts a fresh note (low phase first), force_low parks the output low,
// run advances the counter. wrap flags the cycle on which the output toggles.
module tone_gen
    import tone_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HALF_W-1:0] half,
    input  logic              run,
    input  logic              load,
    input  logic              force_low,
    output logic              speaker,
    output logic              wrap
);

    logic [HALF_W-1:0] cnt_r;
    logic              spk_r;

    // A half of 0 or 1 degenerates to a toggle every cycle rather than wrapping.
    assign wrap    = run && (({1'b0, cnt_r} + 21'd1) >= {1'b0, half});
    assign speaker = spk_r;

    // Counter and toggle flop; load/force_low take precedence over running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 20'd0;
            spk_r <= 1'b0;
        end else if (load || force_low) begin
            cnt_r <= 20'd0;
            spk_r <= 1'b0;
        end else if (wrap) begin
            cnt_r <= 20'd0;
            spk_r <= ~spk_r;
        end else if (run) begin
            cnt_r <= cnt_r + 20'd1;
        end
    end

endmodule

// File: rtl/tone_source_arbiter.sv
// Shares the speaker tone path between the live keyboard and the file player.
// Arbitrates ownership, enforces a minimum note hold, only releases the speaker
// on a low phase (click-free), and inserts a silent gap between notes.
module tone_source_arbiter
    import tone_pkg::*;
#(
    parameter int FILE_PRIORITY = 1,
    parameter int MIN_HOLD_CYC  = 2_000_000,
    parameter int GAP_CYC       = 500_000,
    parameter int DIV_SHIFT     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kb_valid,
    input  logic [2:0] kb_note,
    input  logic [2:0] kb_octave,
    input  logic       fp_valid,
    input  logic [2:0] fp_note,
    input  logic [2:0] fp_octave,
    output logic       speaker,
    output logic       grant_kb,
    output logic       grant_fp,
    output logic       busy,
    output logic [2:0] cur_note,
    output logic [2:0] cur_octave
);

    localparam logic FP_WINS = (FILE_PRIORITY != 0);
    localparam logic GAP_EN  = (GAP_CYC != 0);

    state_t            state_r;
    state_t            state_n;
    logic              grant_kb_r;
    logic              grant_fp_r;
    logic              busy_r;
    logic [2:0]        cur_note_r;
    logic [2:0]        cur_octave_r;
    logic [31:0]       hold_cnt_r;
    logic [31:0]       gap_cnt_r;

    logic              req_kb_s;
    logic              req_fp_s;
    logic [2:0]        kb_oct_c_s;
    logic [2:0]        fp_oct_c_s;
    logic              pick_fp_s;
    logic              own_req_s;
    logic              own_diff_s;
    logic              other_pre_s;
    logic              hold_done_s;
    logic              load_s;
    logic              run_s;
    logic              force_low_s;
    logic              speaker_s;
    logic              wrap_s;
    logic [5:0]        shift_s;
    logic [HALF_W-1:0] half_s;

    assign req_kb_s    = kb_valid && (kb_note != NOTE_REST);
    assign req_fp_s    = fp_valid && (fp_note != NOTE_REST);
    assign kb_oct_c_s  = clamp_octave(kb_octave);
    assign fp_oct_c_s  = clamp_octave(fp_octave);
    assign pick_fp_s   = req_fp_s && (!req_kb_s || FP_WINS);
    assign hold_done_s = (hold_cnt_r == 32'(MIN_HOLD_CYC));
    assign shift_s     = {3'b000, cur_octave_r} + 6'(DIV_SHIFT);
    assign half_s      = base_half(cur_note_r) >> shift_s;

    // Change-event inputs as seen from the currently granted source.
    always_comb begin
        own_req_s   = 1'b0;
        own_diff_s  = 1'b0;
        other_pre_s = 1'b0;
        if (grant_fp_r) begin
            own_req_s   = req_fp_s;
            own_diff_s  = (fp_note != cur_note_r) || (fp_oct_c_s != cur_octave_r);
            other_pre_s = req_kb_s && !FP_WINS;
        end else begin
            own_req_s   = req_kb_s;
            own_diff_s  = (kb_note != cur_note_r) || (kb_oct_c_s != cur_octave_r);
            other_pre_s = req_fp_s && FP_WINS;
        end
    end

    // Arbiter next-state and tone-generator controls.
    always_comb begin
        state_n     = state_r;
        load_s      = 1'b0;
        run_s       = 1'b0;
        force_low_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_kb_s || req_fp_s) begin
                    load_s  = 1'b1;
                    state_n = PLAY;
                end else begin
                    state_n = IDLE;
                end
            end
            PLAY: begin
                run_s = 1'b1;
                // A dropped request releases at once; other changes wait out the hold.
                if (!own_req_s || (hold_done_s && (own_diff_s || other_pre_s))) begin
                    state_n = DRAIN;
                end else begin
                    state_n = PLAY;
                end
            end
            DRAIN: begin
                run_s = 1'b1;
                // Release when already low or on the falling toggle.
                if (!speaker_s || wrap_s) begin
                    force_low_s = 1'b1;
                    state_n     = GAP_EN ? GAP : IDLE;
                end else begin
                    state_n = DRAIN;
                end
            end
            GAP: begin
                if ((gap_cnt_r + 32'd1) >= 32'(GAP_CYC)) begin
                    state_n = IDLE;
                end else begin
                    state_n = GAP;
                end
            end
            default: begin
                force_low_s = 1'b1;
                state_n     = IDLE;
            end
        endcase
    end

    // State, ownership, latched note and hold/gap counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            grant_kb_r   <= 1'b0;
            grant_fp_r   <= 1'b0;
            busy_r       <= 1'b0;
            cur_note_r   <= 3'd0;
            cur_octave_r <= 3'd0;
            hold_cnt_r   <= 32'd0;
            gap_cnt_r    <= 32'd0;
        end else begin
            state_r <= state_n;
            busy_r  <= (state_n != IDLE);
            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        grant_fp_r   <= pick_fp_s;
                        grant_kb_r   <= !pick_fp_s;
                        cur_note_r   <= pick_fp_s ? fp_note : kb_note;
                        cur_octave_r <= pick_fp_s ? fp_oct_c_s : kb_oct_c_s;
                        hold_cnt_r   <= 32'd0;
                        gap_cnt_r    <= 32'd0;
                    end
                end
                PLAY: begin
                    if (!hold_done_s) begin
                        hold_cnt_r <= hold_cnt_r + 32'd1;
                    end
                end
                DRAIN: begin
                    if (force_low_s) begin
                        grant_kb_r   <= 1'b0;
                        grant_fp_r   <= 1'b0;
                        cur_note_r   <= 3'd0;
                        cur_octave_r <= 3'd0;
                        hold_cnt_r   <= 32'd0;
                        gap_cnt_r    <= 32'd0;
                    end
                end
                GAP: begin
                    gap_cnt_r <= gap_cnt_r + 32'd1;
                end
                default: begin
                    grant_kb_r <= 1'b0;
                    grant_fp_r <= 1'b0;
                end
            endcase
        end
    end

    tone_gen u_tone_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .half      (half_s),
        .run       (run_s),
        .load      (load_s),
        .force_low (force_low_s),
        .speaker   (speaker_s),
        .wrap      (wrap_s)
    );

    assign speaker    = speaker_s;
    assign grant_kb   = grant_kb_r;
    assign grant_fp   = grant_fp_r;
    assign busy       = busy_r;
    assign cur_note   = cur_note_r;
    assign cur_octave = cur_octave_r;

endmodule

// File: tb/tb_tone_source_arbiter.sv
// Bench for tone_source_arbiter: two instances (file priority and keyboard
// priority) share the same stimulus. Expected outputs come from a note-level
// reference model that predicts speaker phase from grant time and half period.
module tb_tone_source_arbiter;

    localparam int MIN_HOLD = 1000;
    localparam int GAP      = 50;
    localparam int SHIFT    = 10;

    typedef struct packed {
        logic       speaker;
        logic       grant_kb;
        logic       grant_fp;
        logic       busy;
        logic [2:0] note;
        logic [2:0] octave;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t exp_k;
        obs_t exp_f;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       kb_valid, fp_valid;
    logic [2:0] kb_note, kb_octave, fp_note, fp_octave;

    logic       spk_f, gkb_f, gfp_f, busy_f;
    logic [2:0] note_f, oct_f;
    logic       spk_k, gkb_k, gfp_k, busy_k;
    logic [2:0] note_k, oct_k;
    obs_t       obs_f, obs_k;

    assign obs_f = {spk_f, gkb_f, gfp_f, busy_f, note_f, oct_f};
    assign obs_k = {spk_k, gkb_k, gfp_k, busy_k, note_k, oct_k};

    tone_source_arbiter #(.FILE_PRIORITY(1), .MIN_HOLD_CYC(MIN_HOLD), .GAP_CYC(GAP), .DIV_SHIFT(SHIFT)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .kb_valid(kb_valid), .kb_note(kb_note), .kb_octave(kb_octave),
        .fp_valid(fp_valid), .fp_note(fp_note), .fp_octave(fp_octave),
        .speaker(spk_f), .grant_kb(gkb_f), .grant_fp(gfp_f), .busy(busy_f),
        .cur_note(note_f), .cur_octave(oct_f)
    );

    tone_source_arbiter #(.FILE_PRIORITY(0), .MIN_HOLD_CYC(MIN_HOLD), .GAP_CYC(GAP), .DIV_SHIFT(SHIFT)) dut_k (
        .clk(clk), .rst_n(rst_n),
        .kb_valid(kb_valid), .kb_note(kb_note), .kb_octave(kb_octave),
        .fp_valid(fp_valid), .fp_note(fp_note), .fp_octave(fp_octave),
        .speaker(spk_k), .grant_kb(gkb_k), .grant_fp(gfp_k), .busy(busy_k),
        .cur_note(note_k), .cur_octave(oct_k)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    obs_t last_f;

    // Stimulus state applied on each drive
    logic       s_rst = 1'b0;
    logic       s_kv = 1'b0, s_fv = 1'b0;
    logic [2:0] s_kn = 3'd0, s_ko = 3'd0, s_fn = 3'd0, s_fo = 3'd0;

    // Reference model, index 0 = keyboard priority, 1 = file priority.
    // owner: 0 none, 1 keyboard, 2 file player. rel = cycle the speaker is released (-1 none).
    int base_tab [8] = '{0, 764455, 681050, 606745, 572692, 510209, 454545, 404956};
    int m_owner [2] = '{0, 0};
    int m_note  [2] = '{0, 0};
    int m_oct   [2] = '{0, 0};
    int m_half  [2] = '{1, 1};
    int m_tg    [2] = '{0, 0};
    int m_rel   [2] = '{-1, -1};
    int m_idle  [2] = '{0, 0};

    task automatic model_step(input int p, input int n, output obs_t o);
        bit rk, rf, own_req, diff, other;
        int kn, kc, fn, fc, hold, ph;
        o  = '0;
        kn = int'(kb_note);
        fn = int'(fp_note);
        kc = (int'(kb_octave) > 6) ? 6 : int'(kb_octave);
        fc = (int'(fp_octave) > 6) ? 6 : int'(fp_octave);
        rk = kb_valid && (kn != 0);
        rf = fp_valid && (fn != 0);
        if (!rst_n) begin
            m_owner[p] = 0;
            m_rel[p]   = -1;
            m_idle[p]  = 0;
            return;
        end
        if (m_owner[p] != 0 && m_rel[p] >= 0) begin
            if (n == m_rel[p]) begin
                m_owner[p] = 0;
                m_rel[p]   = -1;
                m_idle[p]  = n + GAP + 1;
            end
        end else if (m_owner[p] != 0) begin
            own_req = (m_owner[p] == 2) ? rf : rk;
            diff    = (m_owner[p] == 2) ? (fn != m_note[p] || fc != m_oct[p])
                                        : (kn != m_note[p] || kc != m_oct[p]);
            other   = (m_owner[p] == 2) ? (rk && p == 0) : (rf && p == 1);
            hold    = (n - 1 - m_tg[p] > MIN_HOLD) ? MIN_HOLD : (n - 1 - m_tg[p]);
            if (!own_req || (hold == MIN_HOLD && (diff || other))) begin
                ph = (n - m_tg[p]) / m_half[p];
                if (ph % 2 == 0) m_rel[p] = n + 1;
                else             m_rel[p] = m_tg[p] + (ph + 1) * m_half[p];
            end
        end else if (n >= m_idle[p] && (rk || rf)) begin
            if (rf && (!rk || p == 1)) begin
                m_owner[p] = 2; m_note[p] = fn; m_oct[p] = fc;
            end else begin
                m_owner[p] = 1; m_note[p] = kn; m_oct[p] = kc;
            end
            m_half[p] = base_tab[m_note[p]] >> (m_oct[p] + SHIFT);
            m_tg[p]   = n;
        end
        if (m_owner[p] != 0) begin
            o.speaker  = (((n - m_tg[p]) / m_half[p]) % 2) == 1;
            o.grant_kb = (m_owner[p] == 1);
            o.grant_fp = (m_owner[p] == 2);
            o.busy     = 1'b1;
            o.note     = 3'(m_note[p]);
            o.octave   = 3'(m_oct[p]);
        end else begin
            o.busy = (n < m_idle[p] - 1);
        end
    endtask

    // Apply current stimulus for the next rising edge and queue its expected outcome
    task automatic drive();
        exp_t e;
        @(negedge clk);
        rst_n = s_rst; kb_valid = s_kv; kb_note = s_kn; kb_octave = s_ko;
        fp_valid = s_fv; fp_note = s_fn; fp_octave = s_fo;
        model_step(0, cyc, e.exp_k);
        model_step(1, cyc, e.exp_f);
        e.cyc  = cyc;
        last_f = e.exp_f;
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive();
    endtask

    task automatic set_kb(input logic v, input logic [2:0] n, input logic [2:0] o);
        s_kv = v; s_kn = n; s_ko = o;
    endtask

    task automatic set_fp(input logic v, input logic [2:0] n, input logic [2:0] o);
        s_fv = v; s_fn = n; s_fo = o;
    endtask

    task automatic compare(input string name, input int c, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got spk=%0b gkb=%0b gfp=%0b busy=%0b note=%0d oct=%0d, expected spk=%0b gkb=%0b gfp=%0b busy=%0b note=%0d oct=%0d",
                     name, c, got.speaker, got.grant_kb, got.grant_fp, got.busy, got.note, got.octave,
                     exp.speaker, exp.grant_kb, exp.grant_fp, exp.busy, exp.note, exp.octave);
        end
    endtask

    // Monitor: after every rising edge, compare both instances against the queued expectation
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            compare("file_prio", mon_e.cyc, obs_f, mon_e.exp_f);
            compare("kb_prio", mon_e.cyc, obs_k, mon_e.exp_k);
        end
    end

    int kb_left = 0;
    int fp_left = 0;
    int guard;

    initial begin
        rst_n = 1'b0; kb_valid = 1'b0; fp_valid = 1'b0;
        kb_note = 3'd0; kb_octave = 3'd0; fp_note = 3'd0; fp_octave = 3'd0;

        // Reset state
        s_rst = 1'b0;
        run(4);
        s_rst = 1'b1;
        run(3);

        // File player A octave 2 held, then released
        set_fp(1'b1, 3'd6, 3'd2);
        run(1200);
        set_fp(1'b0, 3'd0, 3'd0);
        run(900);

        // Both request on the same cycle
        set_kb(1'b1, 3'd3, 3'd3);
        set_fp(1'b1, 3'd5, 3'd3);
        run(1300);
        set_kb(1'b0, 3'd0, 3'd0);
        set_fp(1'b0, 3'd0, 3'd0);
        run(900);

        // Keyboard C oct0, note changes to E after 200 cycles
        set_kb(1'b1, 3'd1, 3'd0);
        run(200);
        set_kb(1'b1, 3'd3, 3'd0);
        run(2200);
        set_kb(1'b0, 3'd0, 3'd0);
        run(900);

        // File player A oct1 drops its request while the speaker is high
        set_fp(1'b1, 3'd6, 3'd1);
        run(300);
        set_fp(1'b0, 3'd6, 3'd1);
        run(400);

        // Keyboard B octave 7 is clamped to 6
        set_kb(1'b1, 3'd7, 3'd7);
        run(300);
        set_kb(1'b0, 3'd0, 3'd0);
        run(200);

        // Keyboard playing, file player arrives later
        set_kb(1'b1, 3'd2, 3'd1);
        run(100);
        set_fp(1'b1, 3'd4, 3'd2);
        run(1800);
        set_kb(1'b0, 3'd0, 3'd0);
        set_fp(1'b0, 3'd0, 3'd0);
        run(900);

        // Asynchronous reset while the speaker is high, then re-grant
        set_kb(1'b1, 3'd5, 3'd3);
        guard = 0;
        drive();
        while (!(last_f.speaker && last_f.grant_kb) && guard < 500) begin
            drive();
            guard++;
        end
        checks++;
        if (guard >= 500) begin
            errors++;
            $display("FAIL reset_setup: speaker never high within 500 cycles");
        end
        s_rst = 1'b0;
        drive();
        #1;
        checks++;
        if ({spk_f, gkb_f, gfp_f, busy_f} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_immediate: got spk/gkb/gfp/busy=%4b, expected 0000",
                     {spk_f, gkb_f, gfp_f, busy_f});
        end
        run(2);
        s_rst = 1'b1;
        run(300);
        set_kb(1'b0, 3'd0, 3'd0);
        run(900);

        // Randomised traffic from both sources
        for (int i = 0; i < 25000; i++) begin
            if (kb_left <= 0) begin
                set_kb(1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                kb_left = $urandom_range(20, 2500);
            end
            if (fp_left <= 0) begin
                set_fp(1'($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                fp_left = $urandom_range(20, 2500);
            end
            s_rst = 1'($urandom_range(0, 7999) != 0);
            drive();
            kb_left--;
            fp_left--;
        end
        s_rst = 1'b1;
        run(2);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
